dram_sipo_deser: RTL and testbench
==================================

Name: dram_sipo_deser

Overview:
- Parametrised multi-lane serial-in/parallel-out deserialiser for the DRAM read-data path.
- Each of LANES serial lanes shifts in RATIO bits per word. A completed word is staged in an output holding register and released through a valid/ready handshake.
- Supports MSB-/LSB-first bit order, burst realignment and sticky overflow detection. Sits between the DQ capture stage and the read-return FIFO.

Parameters:
- LANES, 8, number of serial lanes (DQ bits), >=1
- RATIO, 8, bits per lane per word (deserialisation ratio), >=2
- MSB_FIRST, 1, 1: first serial bit lands in the lane's MSB; 0: in the lane's LSB

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds one bit per lane this cycle
- in_data  in  LANES  serial bit of each lane
- align  in  1  restart word boundary: discard the partial word, reset the bit counter
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  consumer accepts the word when out_valid & out_ready
- out_data  out  LANES*RATIO  lane l occupies bits [l*RATIO +: RATIO]
- overflow  out  1  sticky: a completed word was dropped
- clr_ovf  in  1  clears overflow
- out_par  out  LANES  per-lane even parity; present only with the macro

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: bit counter 0, shift registers 0, out_valid 0, out_data 0, overflow 0, out_par 0.
- Priority per cycle: rst > align > in_valid.
- Shift:
  - On in_valid, each lane shifts in in_data[l]. The bit counter increments modulo RATIO; width is clog2(RATIO), with explicit wrap at RATIO-1 (also correct for non-power-of-2 RATIO).
  - MSB_FIRST=1 shifts left, so the first bit ends in bit RATIO-1. MSB_FIRST=0 shifts right, so the first bit ends in bit 0.
- Word completion: in_valid while the counter is RATIO-1. The assembled word, including that cycle's bit, loads the holding register at the same edge. out_valid rises the next cycle.
  - Latency: 1 cycle from the last serial bit to out_valid.
- Holding register:
  - out_valid falls when out_valid & out_ready and no new word completes that cycle.
  - Completion with the register empty, or being drained the same cycle (out_valid & out_ready): the new word loads and out_valid stays/goes 1. No bubble; back-to-back words are sustained at 1 word per RATIO beats.
  - Completion while out_valid=1 & out_ready=0: the new word is dropped, the held word is unchanged, and overflow is set.
  - out_data is stable while out_valid=1 & out_ready=0.
- in_valid=0: shift registers and counter hold. Gaps mid-word are legal.
- align:
  - The counter goes to 0 and the partial contents become don't-care. in_data on an align cycle is NOT captured.
  - The holding register and out_valid are unaffected.
- overflow:
  - clr_ovf clears it.
  - If clr_ovf and a new drop coincide, set wins (overflow stays 1).
- rst mid-word or with out_valid=1: everything returns to reset values on that edge. The pending word is lost and overflow is not set.

Optional Feature:
- Macro: DRAM_SIPO_PARITY_EN.
- Defined: port out_par[LANES-1:0] exists. out_par[l] is the XOR of lane l's RATIO bits, registered alongside out_data with identical load/hold timing.
- Not defined: the out_par port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package dram_sipo_pkg:
  - default LANES/RATIO constants
  - localparam-style function for the counter width (clog2)
  - lane-slice index function lane_lsb(l) = l*RATIO
- Sub-module dram_sipo_lane: one RATIO-bit shift register with shift-enable and MSB_FIRST direction, instantiated LANES times by generate. The counter, holding register and handshake stay in the top.

Test Plan (LANES=2, RATIO=4, MSB_FIRST=1 unless stated):
- Reset/basic: rst 1 cycle; 4 beats with in_valid=1, lane0 1,0,1,1 and lane1 0,0,0,1; out_ready=1 -> out_valid=1 one cycle after beat 4, out_data=8'h1B (lane1=4'h1, lane0=4'hB), then 0.
- MSB_FIRST=0, same stimulus -> out_data=8'h8D.
- Backpressure: out_ready=0, two full words streamed -> first word held stable, second dropped, overflow=1; clr_ovf -> overflow=0; clr_ovf coincident with a third drop -> overflow stays 1.
- Back-to-back with same-cycle drain: out_ready=1, continuous 8 beats -> two words, out_valid high exactly 1 cycle each, no overflow.
- Gaps and align: 2 beats, in_valid=0 for 3 cycles, align=1, then 4 beats of lane0=1,1,1,1 and lane1=0,0,0,0 -> single word 8'h0F; pre-align bits are absent.
- Reset mid-word / parity: rst after 2 beats -> no word produced, all outputs 0. With DRAM_SIPO_PARITY_EN, word 8'h1B -> out_par=2'b11 (lane1 4'h1 odd, lane0 4'hB odd).

Source files
------------

// File: rtl/dram_sipo_pkg.sv
// Shared constants and helpers for the dram_sipo_deser read-data deserialiser.
package dram_sipo_pkg;

    localparam int DEF_LANES = 8;
    localparam int DEF_RATIO = 8;

    // Bit-counter width; a ratio of 2 still needs one bit.
    function automatic int cnt_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    function automatic int lane_lsb(input int l, input int ratio);
        return l * ratio;
    endfunction

endpackage

// File: rtl/dram_sipo_lane.sv
// One serial lane: RATIO-bit shift register, direction fixed by MSB_FIRST.
module dram_sipo_lane #(
    parameter int RATIO     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             din,
    output logic [RATIO-1:0] q_next
);

    logic [RATIO-1:0] q_p0;

    // q_next already contains this cycle's bit so a completing word can load directly.
    always_comb begin
        q_next = q_p0;
        if (shift_en) begin
            q_next = (MSB_FIRST != 0) ? {q_p0[RATIO-2:0], din} : {din, q_p0[RATIO-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_p0 <= '0;
        end else begin
            q_p0 <= q_next;
        end
    end

endmodule

// File: rtl/dram_sipo_deser.sv
// Multi-lane SIPO deserialiser with valid/ready holding register and sticky overflow.
// Optional per-lane even parity output when DRAM_SIPO_PARITY_EN is defined.
module dram_sipo_deser
    import dram_sipo_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int RATIO     = DEF_RATIO,
    parameter int MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [LANES-1:0]       in_data,
    input  logic                   align,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*RATIO-1:0] out_data,
    output logic                   overflow,
`ifdef DRAM_SIPO_PARITY_EN
    output logic [LANES-1:0]       out_par,
`endif
    input  logic                   clr_ovf
);

    localparam int CW = cnt_w(RATIO);
    localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

    logic [CW-1:0]          cnt_p0;
    logic [LANES*RATIO-1:0] word_nxt;
    logic                   shift_en;
    logic                   word_done;
    logic                   load;
    logic                   drop;

    // align wins over in_valid: its bit is never shifted in
    assign shift_en  = in_valid & ~align;
    assign word_done = shift_en & (cnt_p0 == CNT_MAX);
    assign load      = word_done & (~out_valid | out_ready);
    assign drop      = word_done & out_valid & ~out_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dram_sipo_lane #(
            .RATIO     (RATIO),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en),
            .din      (in_data[l]),
            .q_next   (word_nxt[lane_lsb(l, RATIO) +: RATIO])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (align) begin
            cnt_p0 <= '0;
        end else if (in_valid) begin
            cnt_p0 <= (cnt_p0 == CNT_MAX) ? '0 : cnt_p0 + 1'b1;
        end
    end

    // Holding register stage: load on completion when empty or draining this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= word_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef DRAM_SIPO_PARITY_EN
    logic [LANES-1:0] par_nxt;

    for (genvar l = 0; l < LANES; l++) begin : g_par
        assign par_nxt[l] = ^word_nxt[lane_lsb(l, RATIO) +: RATIO];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_par <= '0;
        end else if (load) begin
            out_par <= par_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_dram_sipo_deser.sv
// Directed bench for dram_sipo_deser (LANES=2, RATIO=4), MSB- and LSB-first instances.
module tb_dram_sipo_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = 2'b00;
    logic       align = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_ovf = 1'b0;

    logic       m_valid, l_valid, m_ovf, l_ovf;
    logic [7:0] m_data, l_data;
`ifdef DRAM_SIPO_PARITY_EN
    logic [1:0] m_par, l_par;
`endif

    int total = 0;
    int bad = 0;

    // word 8'h1B: lane1 0,0,0,1 / lane0 1,0,1,1 ; word 8'hF6: lane1 1,1,1,1 / lane0 0,1,1,0
    logic [1:0] w_1b [4] = '{2'b01, 2'b00, 2'b01, 2'b11};
    logic [1:0] w_f6 [4] = '{2'b10, 2'b11, 2'b11, 2'b10};

    always #5 clk = ~clk;

    dram_sipo_deser #(.LANES(2), .RATIO(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .align(align),
        .out_valid(m_valid), .out_ready(out_ready), .out_data(m_data), .overflow(m_ovf),
`ifdef DRAM_SIPO_PARITY_EN
        .out_par(m_par),
`endif
        .clr_ovf(clr_ovf)
    );

    dram_sipo_deser #(.LANES(2), .RATIO(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .align(align),
        .out_valid(l_valid), .out_ready(out_ready), .out_data(l_data), .overflow(l_ovf),
`ifdef DRAM_SIPO_PARITY_EN
        .out_par(l_par),
`endif
        .clr_ovf(clr_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 2'b00;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 2'b11;
        do_reset();
        in_valid = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", m_data); end
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", m_ovf); end
`ifdef DRAM_SIPO_PARITY_EN
        total++; if (m_par !== 2'b00) begin bad++; $display("FAIL reset_par got=%b exp=00", m_par); end
`endif
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) beat(w_1b[i]);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", m_valid); end
        beat(w_1b[3]);
        in_valid = 1'b0;
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", m_valid); end
        total++; if (m_data !== 8'h1B) begin bad++; $display("FAIL basic_data got=%h exp=1b", m_data); end
`ifdef DRAM_SIPO_PARITY_EN
        total++; if (m_par !== 2'b11) begin bad++; $display("FAIL basic_par got=%b exp=11", m_par); end
`endif
        idle();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", m_valid); end
    endtask

    task automatic test_lsb_first();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(w_1b[i]);
        in_valid = 1'b0;
        total++; if (l_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid got=%b exp=1", l_valid); end
        total++; if (l_data !== 8'h8D) begin bad++; $display("FAIL lsb_data got=%h exp=8d", l_data); end
        idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(w_1b[i]);
        for (int i = 0; i < 4; i++) begin
            beat(w_f6[i]);
            total++; if (m_data !== 8'h1B || m_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold beat%0d got=%h/%b exp=1b/1", i, m_data, m_valid);
            end
        end
        in_valid = 1'b0;
        total++; if (m_ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf_set got=%b exp=1", m_ovf); end
        clr_ovf = 1'b1;
        idle();
        clr_ovf = 1'b0;
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL bp_ovf_clr got=%b exp=0", m_ovf); end
        for (int i = 0; i < 3; i++) beat(w_f6[i]);
        clr_ovf = 1'b1;
        beat(w_f6[3]);
        clr_ovf = 1'b0;
        in_valid = 1'b0;
        total++; if (m_ovf !== 1'b1) begin bad++; $display("FAIL bp_set_wins got=%b exp=1", m_ovf); end
        total++; if (m_data !== 8'h1B) begin bad++; $display("FAIL bp_third_drop got=%h exp=1b", m_data); end
        out_ready = 1'b1;
        clr_ovf = 1'b1;
        idle();
        clr_ovf = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [8];
        logic       exp_v [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            seq[i]     = w_1b[i];
            seq[i + 4] = w_f6[i];
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat(seq[i]);
            total++; if (m_valid !== exp_v[i]) begin
                bad++; $display("FAIL b2b_valid beat%0d got=%b exp=%b", i, m_valid, exp_v[i]);
            end
            if (i == 3) begin
                total++; if (m_data !== 8'h1B) begin bad++; $display("FAIL b2b_w1 got=%h exp=1b", m_data); end
            end
        end
        in_valid = 1'b0;
        total++; if (m_data !== 8'hF6) begin bad++; $display("FAIL b2b_w2 got=%h exp=f6", m_data); end
        idle();
        total++; if (m_valid !== 1'b0 || m_ovf !== 1'b0) begin
            bad++; $display("FAIL b2b_end got=%b/%b exp=0/0", m_valid, m_ovf);
        end
    endtask

    task automatic test_drain_load();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(w_1b[i]);
        for (int i = 0; i < 3; i++) beat(w_f6[i]);
        out_ready = 1'b1;
        beat(w_f6[3]);
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (m_valid !== 1'b1 || m_data !== 8'hF6) begin
            bad++; $display("FAIL drain_load got=%b/%h exp=1/f6", m_valid, m_data);
        end
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL drain_load_ovf got=%b exp=0", m_ovf); end
        out_ready = 1'b1;
        idle();
    endtask

    task automatic test_align();
        out_ready = 1'b1;
        beat(2'b11);
        beat(2'b10);
        for (int i = 0; i < 3; i++) idle();
        align    = 1'b1;
        in_valid = 1'b1;
        in_data  = 2'b11;
        tick();
        align = 1'b0;
        for (int i = 0; i < 3; i++) beat(2'b01);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL align_early got=%b exp=0", m_valid); end
        beat(2'b01);
        in_valid = 1'b0;
        total++; if (m_valid !== 1'b1 || m_data !== 8'h0F) begin
            bad++; $display("FAIL align_word got=%b/%h exp=1/0f", m_valid, m_data);
        end
        idle();
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        for (int i = 0; i < 8; i++) beat(w_1b[i % 4]);
        beat(2'b11);
        beat(2'b11);
        in_valid = 1'b0;
        do_reset();
        total++; if (m_valid !== 1'b0 || m_data !== 8'h00 || m_ovf !== 1'b0) begin
            bad++; $display("FAIL rstmid_outs got=%b/%h/%b exp=0/00/0", m_valid, m_data, m_ovf);
        end
`ifdef DRAM_SIPO_PARITY_EN
        total++; if (m_par !== 2'b00) begin bad++; $display("FAIL rstmid_par got=%b exp=00", m_par); end
`endif
        beat(2'b11);
        beat(2'b11);
        in_valid = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_cnt got=%b exp=0", m_valid); end
        out_ready = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lsb_first();
        test_backpressure();
        test_back_to_back();
        test_drain_load();
        test_align();
        test_reset_midword();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
